multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath select and write-enable. It produces the 2-bit `alu_op` consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = decode funct, 11 = or. It waits on a memory ready handshake for instruction and data accesses.

---
 rtl/mips_ctrl_pkg.sv | 44 ++++
 rtl/multicycle_control.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC      = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ORI_EXEC  = 4'd10,
    ST_ORI_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // Shared with the ALU control decoder, so the values are fixed.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_t;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// and decodes every datapath select/enable from the current state.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ORI:       state_d = ST_ORI_EXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXEC:      state_d = ST_R_WB;
      ST_ORI_EXEC:  state_d = ST_ORI_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Reset masks every output, so a pending memory request drops immediately.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal       = 1'b0;
    state         = 4'd0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          illegal   = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI});
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        ST_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        ST_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        ST_ORI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_OR;
        end
        ST_ORI_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
